// File: rtl/ram_bus_arbiter_if.sv
// Request/grant bus between the GA pipeline stages and the shared RAM controller.
// The slave modport is the arbiter's view; the master modport is the requester/controller side.
interface ram_bus_arbiter_if #(
   parameter int unsigned REQUESTERS = 4,
   parameter int unsigned ADDR_WIDTH = 23,
   parameter int unsigned DATA_WIDTH = 16
);
   logic [REQUESTERS-1:0]            req;
   logic [REQUESTERS-1:0]            grant;
   logic [REQUESTERS*ADDR_WIDTH-1:0] req_addr;
   logic [REQUESTERS*DATA_WIDTH-1:0] req_wdata;
   logic [REQUESTERS-1:0]            req_instr;
   logic [REQUESTERS-1:0]            req_latch;
   logic [REQUESTERS-1:0]            req_ready;
   logic [ADDR_WIDTH-1:0]            ram_addr;
   logic [DATA_WIDTH-1:0]            ram_wdata;
   logic                             ram_instr;
   logic                             ram_latch;
   logic                             ram_ready;

   modport slave (
      input  req, req_addr, req_wdata, req_instr, req_latch, ram_ready,
      output grant, req_ready, ram_addr, ram_wdata, ram_instr, ram_latch
   );

   modport master (
      output req, req_addr, req_wdata, req_instr, req_latch, ram_ready,
      input  grant, req_ready, ram_addr, ram_wdata, ram_instr, ram_latch
   );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Round-robin arbiter sharing one RAM controller between several requesters.
// One transaction outstanding at a time; each grant is capped at MAX_BURST issues
// when another requester is waiting.
module ram_bus_arbiter #(
   parameter int unsigned REQUESTERS = 4,
   parameter int unsigned ADDR_WIDTH = 23,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned MAX_BURST  = 16
) (
   input logic              clk,
   input logic              rst,
   ram_bus_arbiter_if.slave bus
);
   localparam int unsigned OwnerW = $clog2(REQUESTERS);
   localparam int unsigned CandW  = OwnerW + 1;
   localparam int unsigned CntW   = $clog2(MAX_BURST + 1);

   localparam logic [CntW-1:0]   BurstMax = CntW'(MAX_BURST);
   localparam logic [OwnerW-1:0] LastIdx  = OwnerW'(REQUESTERS - 1);
   localparam logic [CandW-1:0]  NumReq   = CandW'(REQUESTERS);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StOwned = 2'd1,
      StWait  = 2'd2
   } state_e;

   state_e                  stateQ, stateD;
   logic [REQUESTERS-1:0]   grantQ, grantD;
   logic [OwnerW-1:0]       ownerQ, ownerD;
   logic [OwnerW-1:0]       lastOwnerQ, lastOwnerD;
   logic [CntW-1:0]         burstCntQ, burstCntD;
   logic                    readyPrevQ;

   logic                    pickFound;
   logic [OwnerW-1:0]       pickIdx;
   logic [CandW-1:0]        candSum;
   logic [OwnerW-1:0]       candIdx;

   logic                    ownerReq;
   logic                    ownerLatch;
   logic                    ownerInstr;
   logic [ADDR_WIDTH-1:0]   ownerAddr;
   logic [DATA_WIDTH-1:0]   ownerWdata;

   logic                    active;
   logic                    othersWaiting;
   logic                    releaseNow;
   logic                    issue;
   logic                    completion;

   // Round-robin search: first requester at or after lastOwner+1, wrapping.
   always_comb begin
      pickFound = 1'b0;
      pickIdx   = '0;
      candSum   = '0;
      candIdx   = '0;
      for (int k = 1; k <= int'(REQUESTERS); k++) begin
         candSum = {1'b0, lastOwnerQ} + CandW'(k);
         if (candSum >= NumReq) begin
            candSum = candSum - NumReq;
         end
         candIdx = candSum[OwnerW-1:0];
         if (!pickFound && bus.req[candIdx]) begin
            pickFound = 1'b1;
            pickIdx   = candIdx;
         end
      end
   end

   // Select the current owner's slot from the flattened request buses.
   always_comb begin
      ownerReq   = 1'b0;
      ownerLatch = 1'b0;
      ownerInstr = 1'b0;
      ownerAddr  = '0;
      ownerWdata = '0;
      for (int i = 0; i < int'(REQUESTERS); i++) begin
         if (ownerQ == OwnerW'(i)) begin
            ownerReq   = bus.req[i];
            ownerLatch = bus.req_latch[i];
            ownerInstr = bus.req_instr[i];
            ownerAddr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            ownerWdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Release beats issue: a latch on the release edge never reaches the controller.
   always_comb begin
      active        = (stateQ != StIdle);
      othersWaiting = |(bus.req & ~grantQ);
      releaseNow    = (stateQ == StOwned) &&
                      (!ownerReq || ((burstCntQ == BurstMax) && othersWaiting));
      issue         = (stateQ == StOwned) && !releaseNow && ownerLatch && bus.ram_ready;
      // Completion needs a fresh low-to-high transition of ram_ready.
      completion    = (stateQ == StWait) && bus.ram_ready && !readyPrevQ;
   end

   // Bus outputs: everything is zero while nobody owns the bus.
   always_comb begin
      bus.grant     = grantQ;
      bus.ram_addr  = active ? ownerAddr : '0;
      bus.ram_wdata = active ? ownerWdata : '0;
      bus.ram_instr = active && ownerInstr;
      bus.ram_latch = (stateQ == StOwned) && !releaseNow && ownerLatch;
      bus.req_ready = '0;
      for (int i = 0; i < int'(REQUESTERS); i++) begin
         if ((stateQ == StOwned) && !releaseNow && (ownerQ == OwnerW'(i))) begin
            bus.req_ready[i] = bus.ram_ready;
         end
      end
   end

   // Next-state logic for arbitration, ownership and burst counting.
   always_comb begin
      stateD     = stateQ;
      grantD     = grantQ;
      ownerD     = ownerQ;
      lastOwnerD = lastOwnerQ;
      burstCntD  = burstCntQ;
      unique case (stateQ)
         StIdle: begin
            if (pickFound) begin
               for (int i = 0; i < int'(REQUESTERS); i++) begin
                  grantD[i] = (pickIdx == OwnerW'(i));
               end
               ownerD    = pickIdx;
               burstCntD = '0;
               stateD    = StOwned;
            end
         end
         StOwned: begin
            if (releaseNow) begin
               grantD     = '0;
               lastOwnerD = ownerQ;
               stateD     = StIdle;
            end else if (issue) begin
               if (burstCntQ != BurstMax) begin
                  burstCntD = burstCntQ + CntW'(1);
               end
               stateD = StWait;
            end
         end
         StWait: begin
            if (completion) begin
               stateD = StOwned;
            end
         end
         default: begin
            grantD = '0;
            stateD = StIdle;
         end
      endcase
   end

   // State registers; reset abandons any in-flight transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ     <= StIdle;
         grantQ     <= '0;
         ownerQ     <= '0;
         lastOwnerQ <= LastIdx;
         burstCntQ  <= '0;
      end else begin
         stateQ     <= stateD;
         grantQ     <= grantD;
         ownerQ     <= ownerD;
         lastOwnerQ <= lastOwnerD;
         burstCntQ  <= burstCntD;
      end
   end

   // Previous-cycle ram_ready, used to detect the completion edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         readyPrevQ <= 1'b0;
      end else begin
         readyPrevQ <= bus.ram_ready;
      end
   end
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter: issued RAM transactions are checked against
// a queue of expected transactions; each scenario task checks grant/ready timing inline.
module tb_ram_bus_arbiter;
   localparam int unsigned NReq = 4;
   localparam int unsigned AW   = 23;
   localparam int unsigned DW   = 16;
   localparam int unsigned MB   = 4;

   logic clk;
   logic rst;

   ram_bus_arbiter_if #(.REQUESTERS(NReq), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ram_bus_arbiter #(
      .REQUESTERS(NReq),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .MAX_BURST (MB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [AW-1:0]   addr;
      logic [DW-1:0]   wdata;
      logic            instr;
      logic [NReq-1:0] grant;
   } txn_t;

   txn_t expQ[$];
   txn_t monExp;
   int   tests      = 0;
   int   fails      = 0;
   int   issueCount = 0;
   bit   lastIssue  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue monitor: sampled mid-cycle, so it sees what the next rising edge will see.
   always @(negedge clk) begin
      if (!rst && bus.ram_latch && bus.ram_ready) begin
         issueCount++;
         lastIssue = 1'b1;
         tests++;
         if (expQ.size() == 0) begin
            fails++;
            $display("FAIL unexpected_issue: got addr=%h grant=%b, required no issue",
                     bus.ram_addr, bus.grant);
         end else begin
            monExp = expQ.pop_front();
            if (bus.ram_addr !== monExp.addr || bus.ram_wdata !== monExp.wdata ||
                bus.ram_instr !== monExp.instr || bus.grant !== monExp.grant) begin
               fails++;
               $display("FAIL issue_txn: got addr=%h wdata=%h instr=%b grant=%b, required addr=%h wdata=%h instr=%b grant=%b",
                        bus.ram_addr, bus.ram_wdata, bus.ram_instr, bus.grant,
                        monExp.addr, monExp.wdata, monExp.instr, monExp.grant);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setSlot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic ins);
      bus.req_addr[i*AW +: AW]  = a;
      bus.req_wdata[i*DW +: DW] = d;
      bus.req_instr[i]          = ins;
   endtask

   task automatic pushExp(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic ins,
                          input logic [NReq-1:0] g);
      txn_t e;
      e.addr  = a;
      e.wdata = d;
      e.instr = ins;
      e.grant = g;
      expQ.push_back(e);
   endtask

   task automatic clearInputs();
      bus.req       = '0;
      bus.req_latch = '0;
      bus.ram_ready = 1'b1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      clearInputs();
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_addr  = '1;
      bus.req_wdata = '1;
      bus.req_instr = '1;
      bus.req       = 4'b1111;
      bus.req_latch = 4'b1111;
      bus.ram_ready = 1'b1;
      step();
      step();
      tests++;
      if (bus.grant !== 4'b0000 || bus.ram_latch !== 1'b0 || bus.ram_addr !== '0 ||
          bus.req_ready !== 4'b0000 || bus.ram_wdata !== '0 || bus.ram_instr !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: got grant=%b latch=%b addr=%h ready=%b, required all zero",
                  bus.grant, bus.ram_latch, bus.ram_addr, bus.req_ready);
      end
      clearInputs();
      rst = 1'b0;
      step();
      tests++;
      if (bus.grant !== 4'b0000) begin
         fails++;
         $display("FAIL reset_idle: got grant=%b, required 0000", bus.grant);
      end
   endtask

   task automatic test_round_robin();
      setSlot(0, 23'h0abcde, 16'h1111, 1'b0);
      setSlot(2, 23'h123456, 16'h2222, 1'b1);
      bus.req = 4'b0101;
      step();
      tests++;
      if (bus.grant !== 4'b0001) begin
         fails++;
         $display("FAIL rr_first: got grant=%b, required 0001", bus.grant);
      end
      tests++;
      if (bus.ram_addr !== 23'h0abcde || bus.ram_wdata !== 16'h1111) begin
         fails++;
         $display("FAIL rr_mux0: got addr=%h wdata=%h, required addr=0abcde wdata=1111",
                  bus.ram_addr, bus.ram_wdata);
      end
      bus.req = 4'b0100;
      step();
      tests++;
      if (bus.grant !== 4'b0000) begin
         fails++;
         $display("FAIL rr_release: got grant=%b, required 0000", bus.grant);
      end
      step();
      tests++;
      if (bus.grant !== 4'b0100 || bus.ram_addr !== 23'h123456 || bus.ram_instr !== 1'b1) begin
         fails++;
         $display("FAIL rr_second: got grant=%b addr=%h instr=%b, required grant=0100 addr=123456 instr=1",
                  bus.grant, bus.ram_addr, bus.ram_instr);
      end
      bus.req = '0;
      step();
      step();
   endtask

   task automatic test_wait_sequence();
      int cnt;
      int latchHigh;
      issueCount = 0;
      setSlot(0, 23'h055aa5, 16'hcafe, 1'b1);
      setSlot(3, 23'h7fffff, 16'hdead, 1'b0);
      bus.req = 4'b0001;
      step();
      tests++;
      if (bus.grant !== 4'b0001) begin
         fails++;
         $display("FAIL wait_grant: got grant=%b, required 0001", bus.grant);
      end
      pushExp(23'h055aa5, 16'hcafe, 1'b1, 4'b0001);
      bus.req_latch = 4'b1001;
      bus.ram_ready = 1'b1;
      #1;
      tests++;
      if (bus.ram_latch !== 1'b1 || bus.req_ready !== 4'b0001) begin
         fails++;
         $display("FAIL wait_pre_issue: got latch=%b ready=%b, required latch=1 ready=0001",
                  bus.ram_latch, bus.req_ready);
      end
      step();
      bus.ram_ready = 1'b0;
      cnt = 0;
      latchHigh = 0;
      while (cnt < 20) begin
         #1;
         if (bus.req_ready[0] === 1'b1) break;
         if (bus.ram_latch !== 1'b0) latchHigh++;
         step();
         cnt++;
         if (cnt == 3) bus.ram_ready = 1'b1;
      end
      bus.req_latch = '0;
      tests++;
      if (cnt != 4 || latchHigh != 0) begin
         fails++;
         $display("FAIL wait_cycles: got %0d wait cycles latchHigh=%0d, required 4 and 0",
                  cnt, latchHigh);
      end
      #5;
      tests++;
      if (issueCount != 1) begin
         fails++;
         $display("FAIL wait_single_pulse: got %0d issues, required 1", issueCount);
      end
      bus.req = '0;
      step();
      step();
   endtask

   task automatic test_burst_cap();
      int n;
      int idle;
      bit done;
      doReset();
      issueCount = 0;
      lastIssue  = 0;
      n    = 0;
      idle = 0;
      done = 0;
      setSlot(0, 23'h000100, 16'h1000, 1'b0);
      setSlot(1, 23'h7ff001, 16'hbeef, 1'b0);
      pushExp(23'h000100, 16'h1000, 1'b0, 4'b0001);
      bus.req       = 4'b0011;
      bus.req_latch = 4'b0001;
      bus.ram_ready = 1'b1;
      for (int cyc = 0; cyc < 80 && !done; cyc++) begin
         step();
         if (lastIssue) begin
            lastIssue = 0;
            n++;
            bus.ram_ready = 1'b0;
            if (n < 4) begin
               setSlot(0, 23'h000100 + AW'(n), 16'h1000 + DW'(n), n[0]);
               pushExp(23'h000100 + AW'(n), 16'h1000 + DW'(n), n[0], 4'b0001);
            end
         end else begin
            bus.ram_ready = 1'b1;
         end
         if (bus.grant === 4'b0000 && n > 0) idle++;
         if (bus.grant === 4'b0010) done = 1;
      end
      tests++;
      if (!done || issueCount != 4 || idle != 1) begin
         fails++;
         $display("FAIL burst_cap: got rotated=%0d issues=%0d idle=%0d, required 1, 4, 1",
                  done, issueCount, idle);
      end
      tests++;
      if (expQ.size() != 0) begin
         fails++;
         $display("FAIL burst_cap_queue: got %0d pending, required 0", expQ.size());
      end
      bus.req       = '0;
      bus.req_latch = '0;
      bus.ram_ready = 1'b1;
      step();
      step();
   endtask

   task automatic test_no_competitor();
      int n;
      int drops;
      issueCount = 0;
      lastIssue  = 0;
      n     = 0;
      drops = 0;
      setSlot(2, 23'h400000, 16'h2000, 1'b1);
      pushExp(23'h400000, 16'h2000, 1'b1, 4'b0100);
      bus.req       = 4'b0100;
      bus.req_latch = 4'b0100;
      bus.ram_ready = 1'b1;
      step();
      for (int cyc = 0; cyc < 120 && n < 10; cyc++) begin
         if (bus.grant !== 4'b0100) drops++;
         step();
         if (lastIssue) begin
            lastIssue = 0;
            n++;
            bus.ram_ready = 1'b0;
            if (n < 10) begin
               setSlot(2, 23'h400000 + AW'(n), 16'h2000 + DW'(n), 1'b1);
               pushExp(23'h400000 + AW'(n), 16'h2000 + DW'(n), 1'b1, 4'b0100);
            end
         end else begin
            bus.ram_ready = 1'b1;
         end
      end
      bus.req_latch = '0;
      step();
      bus.ram_ready = 1'b1;
      step();
      tests++;
      if (issueCount != 10 || drops != 0 || bus.grant !== 4'b0100) begin
         fails++;
         $display("FAIL solo_hold: got issues=%0d drops=%0d grant=%b, required 10, 0, 0100",
                  issueCount, drops, bus.grant);
      end
      tests++;
      if (dut.burstCntQ !== 3'd4) begin
         fails++;
         $display("FAIL solo_burst_cnt: got %0d, required 4", dut.burstCntQ);
      end
      bus.req = '0;
      step();
      step();
   endtask

   task automatic test_drop_in_wait();
      int held;
      issueCount = 0;
      held = 0;
      setSlot(1, 23'h0c0ffe, 16'h5a5a, 1'b0);
      pushExp(23'h0c0ffe, 16'h5a5a, 1'b0, 4'b0010);
      bus.req       = 4'b0010;
      bus.req_latch = 4'b0010;
      bus.ram_ready = 1'b1;
      step();
      tests++;
      if (bus.grant !== 4'b0010) begin
         fails++;
         $display("FAIL drop_grant: got grant=%b, required 0010", bus.grant);
      end
      step();
      bus.req       = '0;
      bus.req_latch = '0;
      // ram_ready stays high: no low seen yet, so this is not a completion.
      step();
      if (bus.grant === 4'b0010) held++;
      step();
      if (bus.grant === 4'b0010) held++;
      bus.ram_ready = 1'b0;
      step();
      if (bus.grant === 4'b0010) held++;
      bus.ram_ready = 1'b1;
      #1;
      if (bus.req_ready === 4'b0000) held++;
      tests++;
      if (held != 4 || issueCount != 1) begin
         fails++;
         $display("FAIL drop_hold_in_wait: got held=%0d issues=%0d, required 4 and 1",
                  held, issueCount);
      end
      step();
      tests++;
      if (bus.grant !== 4'b0010 || bus.req_ready !== 4'b0000 || bus.ram_latch !== 1'b0) begin
         fails++;
         $display("FAIL drop_complete: got grant=%b ready=%b latch=%b, required 0010 0000 0",
                  bus.grant, bus.req_ready, bus.ram_latch);
      end
      step();
      tests++;
      if (bus.grant !== 4'b0000) begin
         fails++;
         $display("FAIL drop_release: got grant=%b, required 0000", bus.grant);
      end
      step();
   endtask

   task automatic test_reset_in_wait();
      issueCount = 0;
      setSlot(3, 23'h3a3a3a, 16'h7777, 1'b1);
      pushExp(23'h3a3a3a, 16'h7777, 1'b1, 4'b1000);
      bus.req       = 4'b1000;
      bus.req_latch = 4'b1000;
      bus.ram_ready = 1'b1;
      step();
      tests++;
      if (bus.grant !== 4'b1000) begin
         fails++;
         $display("FAIL rstwait_grant: got grant=%b, required 1000", bus.grant);
      end
      step();
      bus.ram_ready = 1'b0;
      step();
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if (bus.grant !== 4'b0000 || bus.ram_latch !== 1'b0 || bus.ram_addr !== '0 ||
          issueCount != 1) begin
         fails++;
         $display("FAIL rstwait_async: got grant=%b latch=%b addr=%h issues=%0d, required 0000 0 0 1",
                  bus.grant, bus.ram_latch, bus.ram_addr, issueCount);
      end
      step();
      rst           = 1'b0;
      bus.req       = 4'b1111;
      bus.req_latch = '0;
      bus.ram_ready = 1'b1;
      step();
      tests++;
      if (bus.grant !== 4'b0001) begin
         fails++;
         $display("FAIL rstwait_regrant: got grant=%b, required 0001", bus.grant);
      end
      bus.req = '0;
      step();
      step();
   endtask

   initial begin
      rst = 1'b1;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_instr = '0;
      clearInputs();
      test_reset();
      test_round_robin();
      test_wait_sequence();
      test_burst_cap();
      test_no_competitor();
      test_drop_in_wait();
      test_reset_in_wait();
      tests++;
      if (expQ.size() != 0) begin
         fails++;
         $display("FAIL final_queue: got %0d pending transactions, required 0", expQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required completion before 200000");
      $fatal(1, "timeout");
   end
endmodule
